// File: rtl/simplez_mem_arbiter_if.sv
// Bus bundle between the Simplez CPU, the program loader and the shared 512 x 12 memory.
// The slave modport is the arbiter's view and the master modport is the requester/memory side.
interface simplez_mem_arbiter_if #(
  parameter int ADDRW = 9,
  parameter int DATAW = 12
);
  // Port 0: CPU datapath
  logic             req0;
  logic             we0;
  logic [ADDRW-1:0] addr0;
  logic [DATAW-1:0] wdata0;
  logic             gnt0;
  logic             rvalid0;
  logic [DATAW-1:0] rdata0;

  // Port 1: program loader / debug
  logic             req1;
  logic             we1;
  logic [ADDRW-1:0] addr1;
  logic [DATAW-1:0] wdata1;
  logic             gnt1;
  logic             rvalid1;
  logic [DATAW-1:0] rdata1;
  logic             lock1;

  // Memory side and status
  logic [ADDRW-1:0] mem_addr;
  logic             mem_we;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;
  logic [7:0]       stall_cnt;

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt in the
  // same cycle; dropping req before a grant cancels the access. A granted read
  // returns data with a one-cycle rvalid strobe in the following cycle.
  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output stall_cnt
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  stall_cnt
  );
endinterface

// File: rtl/simplez_mem_arbiter.sv
// Round-robin arbiter sharing the Simplez main memory between the CPU (port 0) and the loader (port 1).
// Optional loader burst lock enabled by defining SIMPLEZ_ARB_LOCK_EN; registers update on the falling edge.
module simplez_mem_arbiter #(
  parameter int ADDRW    = 9,
  parameter int DATAW    = 12,
  parameter int MAX_LOCK = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  simplez_mem_arbiter_if.slave  bus
);

  logic             last;
  logic             gnt0_c;
  logic             gnt1_c;
  logic             rvalid0_q;
  logic             rvalid1_q;
  logic [7:0]       stall_q;
  logic [ADDRW-1:0] addr_sel;
  logic [DATAW-1:0] wdata_sel;
  logic             we_sel;

`ifdef SIMPLEZ_ARB_LOCK_EN
  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  logic [7:0] lock_cnt;
  logic       lock_hold;

  // The loader keeps the memory while locked unless the CPU has waited out the burst limit.
  assign lock_hold = bus.lock1 & bus.req1 & last &
                     ~(bus.req0 & (lock_cnt >= MAX_LOCK_C));
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {bus.lock1, 8'(MAX_LOCK)};
`endif

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (bus.req0 && bus.req1) begin
`ifdef SIMPLEZ_ARB_LOCK_EN
        if (lock_hold) begin
          gnt1_c = 1'b1;
        end else if (last) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
`else
        if (last) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
`endif
      end else begin
        gnt0_c = bus.req0;
        gnt1_c = bus.req1;
      end
    end
  end

  // An idle cycle drives a quiet bus (all zeros) rather than the last address.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    if (gnt0_c) begin
      addr_sel  = bus.addr0;
      wdata_sel = bus.wdata0;
      we_sel    = bus.we0;
    end else if (gnt1_c) begin
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
      we_sel    = bus.we1;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_we    = we_sel;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;
  assign bus.stall_cnt = stall_q;

  always_ff @(negedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      stall_q   <= 8'd0;
`ifdef SIMPLEZ_ARB_LOCK_EN
      lock_cnt  <= 8'd0;
`endif
    end else begin
      if (gnt0_c || gnt1_c) begin
        last <= gnt1_c;
      end
      rvalid0_q <= gnt0_c & ~bus.we0;
      rvalid1_q <= gnt1_c & ~bus.we1;
      if (bus.req0 && !gnt0_c && stall_q != 8'hFF) begin
        stall_q <= stall_q + 8'd1;
      end
`ifdef SIMPLEZ_ARB_LOCK_EN
      // Counts consecutive loader grants under lock; held at the limit until the CPU gets its slot.
      if (!bus.lock1 || gnt0_c) begin
        lock_cnt <= 8'd0;
      end else if (gnt1_c && lock_cnt != MAX_LOCK_C) begin
        lock_cnt <= lock_cnt + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_simplez_mem_arbiter.sv
// Randomized bench for simplez_mem_arbiter against a cycle-level reference model of the arbitration rules.
// Inputs change just after the falling edge; outputs are sampled on the rising edge, mid-cycle.
module tb_simplez_mem_arbiter;
  localparam int ADDRW    = 9;
  localparam int DATAW    = 12;
  localparam int MAX_LOCK = 4;
  localparam int DEPTH    = 1 << ADDRW;

  logic clk = 1'b1;
  logic rst;

  simplez_mem_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  simplez_mem_arbiter #(
    .ADDRW(ADDRW), .DATAW(DATAW), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / memory environment ----------------
  always #5 clk = ~clk;

  logic [DATAW-1:0] ram     [DEPTH];
  logic [DATAW-1:0] ref_mem [DEPTH];

  always @(negedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / model state ----------------
  logic [DATAW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_last, m_burst, m_stall;
  bit m_rv0, m_rv1;
  int g_w;
  logic s_gnt0, s_gnt1, s_rv0, s_rv1, s_we;
  logic [DATAW-1:0] s_rd0, s_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Winner of the current cycle: -1 none, 0 CPU, 1 loader.
  function automatic int model_winner();
    if (rst) return -1;
    if (!bus.req0 && !bus.req1) return -1;
    if (bus.req0 && !bus.req1) return 0;
    if (bus.req1 && !bus.req0) return 1;
`ifdef SIMPLEZ_ARB_LOCK_EN
    if (bus.lock1 && m_last == 1 && m_burst < MAX_LOCK) return 1;
`endif
    return 1 - m_last;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_burst = 0;
    m_stall = 0;
    m_rv0   = 0;
    m_rv1   = 0;
  endtask

  // One memory cycle: check mid-cycle, then advance the model at the falling edge.
  task automatic step();
    int w;
    logic             e_we;
    logic [ADDRW-1:0] e_addr;
    logic [DATAW-1:0] e_wdata;
    logic [DATAW-1:0] e_rd;
    @(posedge clk);
    w = model_winner();
    e_we    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    if (w == 0) begin
      e_we = bus.we0; e_addr = bus.addr0; e_wdata = bus.wdata0;
    end else if (w == 1) begin
      e_we = bus.we1; e_addr = bus.addr1; e_wdata = bus.wdata1;
    end
    check("gnt0", bus.gnt0, w == 0);
    check("gnt1", bus.gnt1, w == 1);
    check("mem_we", bus.mem_we, e_we);
    check("mem_addr", bus.mem_addr, e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("rvalid0", bus.rvalid0, m_rv0);
    check("rvalid1", bus.rvalid1, m_rv1);
    if ((m_rv0 || m_rv1) && exp_q.size() > 0) begin
      e_rd = exp_q.pop_front();
      if (m_rv0) check("rdata0", bus.rdata0, e_rd);
      else       check("rdata1", bus.rdata1, e_rd);
    end
    check("stall_cnt", bus.stall_cnt, m_stall);
    s_gnt0 = bus.gnt0; s_gnt1 = bus.gnt1; s_rv0 = bus.rvalid0; s_rv1 = bus.rvalid1;
    s_rd0 = bus.rdata0; s_rd1 = bus.rdata1; s_we = bus.mem_we;
    g_w = w;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_rv0 = (w == 0) && !e_we;
      m_rv1 = (w == 1) && !e_we;
      if (m_rv0 || m_rv1) exp_q.push_back(ref_mem[e_addr]);
      if (w >= 0 && e_we) ref_mem[e_addr] = e_wdata;
      if (bus.req0 && w != 0 && m_stall < 255) m_stall++;
      if (w >= 0) m_last = w;
      if (!bus.lock1 || w == 0) m_burst = 0;
      else if (w == 1 && m_burst < MAX_LOCK) m_burst++;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic r, input logic we, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic we, input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d);
    bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic idle();
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    bus.lock1 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] seq;
    logic [9:0] exp_seq;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DATAW'(i * 37 + 5);
      ref_mem[i] = DATAW'(i * 37 + 5);
    end
    ram[9'o100]     = 12'o7;
    ref_mem[9'o100] = 12'o7;
    bus.mem_rdata = '0;
    idle();
    rst = 1;
    model_reset();
    @(negedge clk); #1;

    // Reset state
    step();
    step();
    check("reset_stall", bus.stall_cnt, 0);
    rst = 0;

    // CPU alone reads 0o100
    drive0(1, 0, 9'o100, '0);
    step();
    check("t1_gnt0", s_gnt0, 1);
    idle();
    step();
    check("t1_rvalid0", s_rv0, 1);
    check("t1_rdata0", s_rd0, 12'o7);
    check("t1_rvalid1", s_rv1, 0);

    // Tie for 6 cycles
    do_reset();
    drive0(1, 0, 9'd3, '0);
    drive1(1, 0, 9'd4, '0);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      seq = {seq[8:0], s_gnt1};
    end
    check("t2_seq", seq[5:0], 6'b010101);
    check("t2_stall", bus.stall_cnt, 3);

    // Loader write then CPU read of the same word
    idle();
    drive1(1, 1, 9'o010, 12'o1234);
    step();
    check("t3_we_write", s_we, 1);
    idle();
    drive0(1, 0, 9'o010, '0);
    step();
    check("t3_we_read", s_we, 0);
    idle();
    step();
    check("t3_rvalid0", s_rv0, 1);
    check("t3_rdata0", s_rd0, 12'o1234);

    // Locked loader burst against a waiting CPU
    do_reset();
    bus.lock1 = 1;
    drive0(1, 0, 9'd20, '0);
    drive1(1, 0, 9'd21, '0);
    seq = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      seq = {seq[8:0], s_gnt1};
    end
`ifdef SIMPLEZ_ARB_LOCK_EN
    exp_seq = 10'b1111011110;
`else
    exp_seq = 10'b0101010101;
`endif
    check("t4_lock_seq", seq, exp_seq);

    // Stall counter saturation
    do_reset();
    bus.lock1 = 1;
    drive0(1, 0, 9'd30, '0);
    drive1(1, 0, 9'd31, '0);
    for (int i = 0; i < 600; i++) step();
    check("t5_stall_sat", bus.stall_cnt, 255);

    // Reset during a locked burst with a loader read in flight
    do_reset();
    bus.lock1 = 1;
    drive0(1, 0, 9'd40, '0);
    drive1(1, 0, 9'd41, '0);
    step();
    step();
    rst = 1;
    step();
    check("t6_rst_gnt0", s_gnt0, 0);
    check("t6_rst_gnt1", s_gnt1, 0);
    rst = 0;
    bus.lock1 = 0;
    step();
    check("t6_rvalid1", s_rv1, 0);
    check("t6_tie_gnt0", s_gnt0, 1);

    // Random traffic: requests held until granted, occasional lock toggles and resets
    idle();
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0 || g_w == 0)
        drive0($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
               ADDRW'($urandom_range(0, 15)), DATAW'($urandom));
      if (!bus.req1 || g_w == 1)
        drive1($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
               ADDRW'($urandom_range(0, 15)), DATAW'($urandom));
      if ($urandom_range(0, 15) == 0) bus.lock1 = ~bus.lock1;
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0;
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
